volume_envelope: RTL

VOLUME_ENVELOPE -- requirements
Module: volume_envelope

---
 rtl/volume_envelope.sv | 116 +++++++++++
 1 files changed

// File: rtl/volume_envelope.sv
// ADSR-style note gain envelope applied to a signed sample stream.
// Optional macro VOLUME_ENVELOPE_LEGATO_EN: retrigger mid-note reloads the beat count only.
module volume_envelope #(
    parameter int unsigned ATTACK_STEP   = 64,
    parameter int unsigned DECAY_STEP    = 32,
    parameter int unsigned SUSTAIN_LEVEL = 160,
    parameter int unsigned RELEASE_STEP  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_note,
    input  logic [5:0]  duration,
    input  logic        beat,
    input  logic [15:0] sample_in,
    input  logic        sample_in_valid,
    output logic [15:0] sample_out,
    output logic        sample_out_valid,
    output logic [7:0]  gain
);

    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  gain_q, gain_d;
    logic [5:0]  rem_q, rem_d;
    logic [15:0] sample_out_q;
    logic        sample_out_valid_q;

    logic [8:0]  atk_sum, dec_diff, rel_diff;
    logic [7:0]  gain_atk, gain_dec, gain_rel;

    // Bit 8 flags overflow (attack) or borrow (decay/release) so steps saturate.
    assign atk_sum  = {1'b0, gain_q} + 9'(ATTACK_STEP);
    assign dec_diff = {1'b0, gain_q} - 9'(DECAY_STEP);
    assign rel_diff = {1'b0, gain_q} - 9'(RELEASE_STEP);
    assign gain_atk = atk_sum[8] ? 8'hFF : atk_sum[7:0];
    assign gain_dec = (dec_diff[8] || (dec_diff[7:0] < 8'(SUSTAIN_LEVEL))) ? 8'(SUSTAIN_LEVEL)
                                                                            : dec_diff[7:0];
    assign gain_rel = rel_diff[8] ? '0 : rel_diff[7:0];

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        rem_d   = rem_q;
        if (new_note && (duration != '0)) begin
            rem_d = duration;
`ifdef VOLUME_ENVELOPE_LEGATO_EN
            if ((state_q == IDLE) || (state_q == RELEASE))
                state_d = ATTACK;
`else
            state_d = ATTACK;
`endif
        end else if (beat) begin
            unique case (state_q)
                ATTACK, DECAY, SUSTAIN: begin
                    if (rem_q == 6'd1) begin
                        state_d = RELEASE;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - 6'd1;
                        if (state_q == ATTACK) begin
                            gain_d = gain_atk;
                            if (gain_atk == 8'hFF)
                                state_d = DECAY;
                        end else if (state_q == DECAY) begin
                            gain_d = gain_dec;
                            if (gain_dec == 8'(SUSTAIN_LEVEL))
                                state_d = SUSTAIN;
                        end
                    end
                end
                RELEASE: begin
                    gain_d = gain_rel;
                    if (gain_rel == '0)
                        state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gain_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            rem_q   <= rem_d;
        end
    end

    // Signed sample times zero-extended gain; bits [23:8] give floor(sample*gain/256).
    logic signed [24:0] product;
    logic               unused_product_bits;

    assign product             = $signed(sample_in) * $signed({1'b0, gain_q});
    assign unused_product_bits = ^{product[24], product[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out_q       <= '0;
            sample_out_valid_q <= 1'b0;
        end else begin
            sample_out_valid_q <= sample_in_valid;
            if (sample_in_valid)
                sample_out_q <= product[23:8];
        end
    end

    assign sample_out       = sample_out_q;
    assign sample_out_valid = sample_out_valid_q;
    assign gain             = gain_q;

endmodule
